// File: rtl/if_byte_fetch.sv
// Instruction fetch: one 32-bit instruction as four little-endian byte reads on the shared 8-bit port.
// Latency: 6 cycles start-to-valid with continuous grant; lost grant only pauses issue. ID backpressure holds DONE.
module if_byte_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_stall_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic              mem_grant_i,
    input  logic [7:0]        mem_din_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [2:0]          issue_cnt_q, issue_cnt_d;
    logic [1:0]          recv_cnt_q, recv_cnt_d;
    logic                inflight_q, inflight_d;
    logic [23:0]         inst_buf_q, inst_buf_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;

    logic                start;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        inflight_d   = 1'b0;
        inst_buf_d   = inst_buf_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        mem_req  = !rst && (state_q == FETCH) && (issue_cnt_q < 3'd4);
        mem_addr = mem_req ? (fetch_pc_q + ADDR_W'(issue_cnt_q)) : '0;

        start = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && id_ready_i));

        if (flush_i) begin
            // Flush wins over a pending handshake in DONE: that instruction is dropped.
            state_d      = IDLE;
            issue_cnt_d  = 3'd0;
            recv_cnt_d   = 2'd0;
            inst_valid_d = 1'b0;
        end else if (start) begin
            state_d      = FETCH;
            fetch_pc_d   = pc_i;
            issue_cnt_d  = 3'd0;
            recv_cnt_d   = 2'd0;
            inst_valid_d = 1'b0;
        end else if (state_q == FETCH) begin
            if (mem_req && mem_grant_i) begin
                issue_cnt_d = issue_cnt_q + 3'd1;
                inflight_d  = 1'b1;
            end
            // A byte issued last cycle is always captured, regardless of current grant.
            if (inflight_q) begin
                recv_cnt_d = recv_cnt_q + 2'd1;
                case (recv_cnt_q)
                    2'd0: inst_buf_d[7:0]   = mem_din_i;
                    2'd1: inst_buf_d[15:8]  = mem_din_i;
                    2'd2: inst_buf_d[23:16] = mem_din_i;
                    default: begin
                        inst_d       = {mem_din_i, inst_buf_q};
                        inst_pc_d    = fetch_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = DONE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= '0;
            issue_cnt_q  <= 3'd0;
            recv_cnt_q   <= 2'd0;
            inflight_q   <= 1'b0;
            inst_buf_q   <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            inflight_q   <= inflight_d;
            inst_buf_q   <= inst_buf_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign pc_stall_o   = rst || !start;
    assign mem_req_o    = mem_req;
    assign mem_a_o      = mem_addr;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;

endmodule

// File: doc/if_byte_fetch.md
Name: if_byte_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, fetches the 32-bit instruction over the shared 8-bit synchronous-read memory port as four little-endian byte reads, and presents {inst, pc} to ID through a valid/ready handshake.
- Drives the PC register's advance/hold control and honours branch flushes.

Parameters:
ADDR_W, 32, width of PC and byte address
INST_W, 32, instruction width; fixed at 4 bytes, other values unsupported

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pc_i  input  ADDR_W  current PC from PC register
pc_stall_o  output  1  1 = PC register must hold; 0 = PC register advances this edge
flush_i  input  1  branch taken / wrong-path flush; PC register loads target this edge
mem_req_o  output  1  byte-read request to memory arbiter
mem_a_o  output  ADDR_W  byte address; 0 when mem_req_o=0
mem_grant_i  input  1  arbiter grant; a byte is issued in a cycle with mem_req_o and mem_grant_i both 1
mem_din_i  input  8  read data; valid the cycle after the issuing cycle
inst_o  output  INST_W  fetched instruction
inst_pc_o  output  ADDR_W  PC of inst_o
inst_valid_o  output  1  inst_o/inst_pc_o valid
id_ready_i  input  1  ID accepts when inst_valid_o and id_ready_i are both 1

Behaviour:
- Reset (priority over all): state=IDLE, issue count=0, receive count=0, inst_buf=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, mem_req_o=0, mem_a_o=0. pc_stall_o=1 while rst is high.
- States: IDLE, FETCH, DONE.
- Start cycle: state IDLE, or DONE with id_ready_i=1, and flush_i=0.
  - pc_stall_o=0 combinationally in this cycle only.
  - At the edge, latch fetch_pc<=pc_i, clear issue/receive counts, enter FETCH.
- pc_stall_o=1 in every other cycle.
- FETCH issue side:
  - mem_req_o=1 while issue count<4.
  - mem_a_o=fetch_pc+issue count; ADDR_W-bit add, wraps modulo 2^ADDR_W.
  - On grant, issue count increments.
  - Loss of grant pauses issue; it does not abort the fetch.
- FETCH receive side:
  - In the cycle after each issue, mem_din_i is written to inst_buf[8*k+7:8*k], k = receive count; receive count then increments.
  - A byte in flight is always captured, even if grant has dropped.
- Completion: at the edge capturing byte 3:
  - inst_o<={mem_din_i, inst_buf[23:0]}, inst_pc_o<=fetch_pc, inst_valid_o<=1.
  - Enter DONE.
- Latency, full grant: start cycle T; issues in T+1..T+4; bytes in T+2..T+5; inst_valid_o high from T+6. Throughput is one instruction per 6 cycles.
- DONE:
  - Outputs held stable while id_ready_i=0; mem_req_o=0.
  - If id_ready_i=1, this is a start cycle: inst_valid_o<=0 at the edge and the next fetch begins.
- Flush (flush_i=1, rst=0), any state:
  - At the edge: inst_valid_o<=0, state=IDLE, counts cleared; a byte in flight is discarded.
  - During the flush cycle: pc_stall_o=1 and mem_req_o stays as computed. The PC register gives flush priority over stall.
  - The next cycle is a start cycle fetching the branch target.
- Flush in DONE with id_ready_i=1: the instruction is NOT delivered (counted as dropped).
- Misaligned pc_i: fetch the raw bytes at pc..pc+3; no exception.
- Reset mid-fetch: immediate return to the reset state; the byte in flight is discarded.

Test Plan:
- Reset, then pc_i=0, grant=1, memory bytes 0x13,0x05,0x10,0x00 at 0..3 -> mem_a_o 0,1,2,3 in cycles 1..4; inst_o=0x00100513, inst_pc_o=0, inst_valid_o=1 at cycle 6; pc_stall_o=0 only in cycle 0.
- inst_valid_o=1 with id_ready_i=0 for 3 cycles -> inst_o held, mem_req_o=0, pc_stall_o=1; then id_ready_i=1 -> valid drops next edge and the fetch of pc_i=4 starts that cycle.
- Grant low during the cycle that address 2 is requested -> address 2 re-presented next cycle; byte 1 still captured; correct instruction, valid one cycle later (cycle 7).
- flush_i pulse in the cycle after byte 1 is issued, pc_i=0x100 afterward -> no inst_valid_o for the old PC; next fetch addresses 0x100..0x103.
- fetch_pc=0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst asserted mid-fetch -> all outputs 0 at the next edge; after release, the fetch restarts from the current pc_i.
